inference_job_scheduler: RTL
============================

Name: inference_job_scheduler

Overview:
Sequences one inference job at a time between the IP receive path and the accelerator core.
- Captures a completed frame and its sender addresses on the receive-path FRAME_READY pulse.
- Starts the core with the image and metadata, waits for the result, then hands result plus return addresses to the transmit packet builder over a valid/ready handshake.
- Frames arriving while a job is in flight are dropped and counted.

Parameters:
FRAME_BYTES, 785, bytes in DATA_FRAME: byte 0 is metadata, bytes 1..784 are the image.
DROP_CNT_WIDTH, 16, width of the saturating drop counter.
TIMEOUT_CYCLES, 65535, RUN-state watchdog limit. Used only with INFER_TIMEOUT_EN.

Ports:
ACLK  in  1  single clock; all logic on its rising edge
ARESET  in  1  synchronous, active-low reset
FRAME_READY  in  1  one-cycle pulse: DATA_FRAME/SRC_* valid this cycle
DATA_FRAME  in  FRAME_BYTES*8  byte i at bits [i*8+:8]
SRC_IP_ADDRESS  in  32  sender IP
SRC_MAC_ADDRESS  in  48  sender MAC
CORE_START  out  1  one-cycle start pulse to core
CORE_FRAME  out  (FRAME_BYTES-1)*8  latched DATA_FRAME[FRAME_BYTES*8-1:8]
CORE_MODE  out  8  latched DATA_FRAME[7:0]
CORE_DONE  in  1  one-cycle completion pulse from core
CORE_RESULT  in  8  result, valid with CORE_DONE
TX_VALID  out  1  response available
TX_READY  in  1  transmit builder accepts
TX_RESULT  out  8  latched result
TX_DST_IP  out  32  latched SRC_IP_ADDRESS
TX_DST_MAC  out  48  latched SRC_MAC_ADDRESS
BUSY  out  1  high in any state except IDLE
DROP_COUNT  out  DROP_CNT_WIDTH  frames dropped since reset

Behaviour:
- Reset (ARESET==0 at a rising edge) forces the following, from any state including mid-job:
  - state IDLE
  - CORE_START, TX_VALID, BUSY = 0
  - CORE_FRAME, CORE_MODE, TX_RESULT, TX_DST_IP, TX_DST_MAC, DROP_COUNT = 0
- FSM states: IDLE, START, RUN, RESPOND. All outputs are registered.
- IDLE:
  - FRAME_READY=1 latches CORE_FRAME, CORE_MODE, TX_DST_IP and TX_DST_MAC, then moves to START.
  - FRAME_READY=0: stay in IDLE.
- START:
  - CORE_START=1 for exactly this one cycle, then move to RUN unconditionally.
  - FRAME_READY at cycle N gives CORE_START at cycle N+1.
- RUN:
  - CORE_DONE=1 latches TX_RESULT<=CORE_RESULT and moves to RESPOND. TX_VALID=1 from the next cycle.
  - Otherwise stay in RUN.
- RESPOND:
  - TX_VALID=1; TX_RESULT/TX_DST_* held stable until the handshake.
  - TX_VALID && TX_READY moves to IDLE; TX_VALID=0 the following cycle.
  - TX_READY held low means stay in RESPOND indefinitely.
- CORE_DONE outside RUN is ignored; latched data is unchanged.
- Dropping: FRAME_READY in START, RUN or RESPOND leaves the latched job untouched and increments DROP_COUNT by 1. This includes FRAME_READY on the cycle of the RESPOND handshake (that frame is dropped).
- DROP_COUNT saturates at all-ones (no wrap). It is cleared only by reset.
- Minimum job turnaround: FRAME_READY (N), CORE_START (N+1), RUN from N+2.
- Back-to-back jobs: a new frame can be accepted on the first IDLE cycle after a handshake.

Optional Feature:
INFER_TIMEOUT_EN
- Defined:
  - A 16-bit cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES-1 with CORE_DONE=0, latch TX_RESULT<=8'hFF and move to RESPOND.
  - CORE_DONE on that same cycle wins and its CORE_RESULT is latched.
  - A CORE_DONE arriving later (in RESPOND/IDLE) is ignored.
- Undefined: no counter; RUN waits for CORE_DONE indefinitely.

Test Plan:
- Single job: FRAME_READY with byte0=8'h03, IP 10.0.0.5, MAC 02:00:00:00:00:07. CORE_DONE 20 cycles after CORE_START with CORE_RESULT=8'h07; TX_READY=1. Expect:
  - CORE_START exactly 1 cycle after FRAME_READY, CORE_MODE=8'h03
  - TX_VALID one cycle after CORE_DONE, TX_RESULT=8'h07, TX_DST_IP=32'h0A000005, TX_DST_MAC=48'h020000000007
  - BUSY low 1 cycle after the handshake
- Backpressure: TX_READY low 50 cycles then high. Expect TX_VALID and TX_DST_*/TX_RESULT constant for all 50 cycles, one handshake, return to IDLE.
- Drops: three FRAME_READY pulses during RUN, plus one on the handshake cycle. Expect DROP_COUNT=4, CORE_FRAME unchanged, no extra CORE_START.
- Saturation: DROP_CNT_WIDTH=2, 5 drops. Expect DROP_COUNT=2'b11.
- Reset mid-job: ARESET low one cycle during RUN. Expect all outputs 0 next cycle; a later CORE_DONE is ignored; a new FRAME_READY starts a fresh job.
- Timeout (INFER_TIMEOUT_EN, TIMEOUT_CYCLES=16): no CORE_DONE. Expect TX_VALID with TX_RESULT=8'hFF 16 cycles after RUN entry. A variant with CORE_DONE on the limit cycle yields CORE_RESULT instead.

Source files
------------

// File: rtl/inference_job_scheduler_if.sv
// Receive, core and transmit signals of the inference job scheduler; master is the scheduler side.
interface inference_job_scheduler_if #(
    parameter int FRAME_BYTES    = 785,
    parameter int DROP_CNT_WIDTH = 16
);
    logic                         FRAME_READY;
    logic [FRAME_BYTES*8-1:0]     DATA_FRAME;
    logic [31:0]                  SRC_IP_ADDRESS;
    logic [47:0]                  SRC_MAC_ADDRESS;
    logic                         CORE_START;
    logic [(FRAME_BYTES-1)*8-1:0] CORE_FRAME;
    logic [7:0]                   CORE_MODE;
    logic                         CORE_DONE;
    logic [7:0]                   CORE_RESULT;
    logic                         TX_VALID;
    logic                         TX_READY;
    logic [7:0]                   TX_RESULT;
    logic [31:0]                  TX_DST_IP;
    logic [47:0]                  TX_DST_MAC;
    logic                         BUSY;
    logic [DROP_CNT_WIDTH-1:0]    DROP_COUNT;

    modport master (
        input  FRAME_READY, DATA_FRAME, SRC_IP_ADDRESS, SRC_MAC_ADDRESS,
               CORE_DONE, CORE_RESULT, TX_READY,
        output CORE_START, CORE_FRAME, CORE_MODE, TX_VALID, TX_RESULT,
               TX_DST_IP, TX_DST_MAC, BUSY, DROP_COUNT
    );

    modport slave (
        output FRAME_READY, DATA_FRAME, SRC_IP_ADDRESS, SRC_MAC_ADDRESS,
               CORE_DONE, CORE_RESULT, TX_READY,
        input  CORE_START, CORE_FRAME, CORE_MODE, TX_VALID, TX_RESULT,
               TX_DST_IP, TX_DST_MAC, BUSY, DROP_COUNT
    );
endinterface

// File: rtl/inference_job_scheduler.sv
// One inference job at a time: receive frame -> core -> TX builder; INFER_TIMEOUT_EN adds a RUN watchdog.
// FRAME_READY->CORE_START 1 cycle, CORE_DONE->TX_VALID 1 cycle; TX_READY low holds the response, frames seen while busy are dropped.
module inference_job_scheduler #(
    parameter int FRAME_BYTES    = 785,
    parameter int DROP_CNT_WIDTH = 16
`ifdef INFER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    inference_job_scheduler_if.master bus
);
    typedef enum logic [1:0] { IDLE, START, RUN, RESPOND } state_t;

    typedef struct packed {
        logic [31:0] ip;
        logic [47:0] mac;
    } hdr_t;

    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

    state_t                       state;
    logic                         core_start_q;
    logic [(FRAME_BYTES-1)*8-1:0] core_frame_q;
    logic [7:0]                   core_mode_q;
    logic                         tx_valid_q;
    logic [7:0]                   tx_result_q;
    hdr_t                         dst_q;
    logic                         busy_q;
    logic [DROP_CNT_WIDTH-1:0]    drop_cnt_q;

`ifdef INFER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            state        <= IDLE;
            core_start_q <= 1'b0;
            core_frame_q <= '0;
            core_mode_q  <= '0;
            tx_valid_q   <= 1'b0;
            tx_result_q  <= '0;
            dst_q        <= '0;
            busy_q       <= 1'b0;
            drop_cnt_q   <= '0;
`ifdef INFER_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            // Any frame outside IDLE is lost, including one on the handshake cycle.
            if (bus.FRAME_READY && (state != IDLE) && (drop_cnt_q != DROP_MAX)) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.FRAME_READY) begin
                        core_frame_q <= bus.DATA_FRAME[FRAME_BYTES*8-1:8];
                        core_mode_q  <= bus.DATA_FRAME[7:0];
                        dst_q        <= {bus.SRC_IP_ADDRESS, bus.SRC_MAC_ADDRESS};
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    core_start_q <= 1'b0;
                    state        <= RUN;
`ifdef INFER_TIMEOUT_EN
                    tmo_cnt      <= '0;
`endif
                end
                RUN: begin
                    if (bus.CORE_DONE) begin
                        tx_result_q <= bus.CORE_RESULT;
                        tx_valid_q  <= 1'b1;
                        state       <= RESPOND;
                    end
`ifdef INFER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        tx_result_q <= 8'hFF;
                        tx_valid_q  <= 1'b1;
                        state       <= RESPOND;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RESPOND: begin
                    if (bus.TX_READY) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.CORE_START = core_start_q;
    assign bus.CORE_FRAME = core_frame_q;
    assign bus.CORE_MODE  = core_mode_q;
    assign bus.TX_VALID   = tx_valid_q;
    assign bus.TX_RESULT  = tx_result_q;
    assign bus.TX_DST_IP  = dst_q.ip;
    assign bus.TX_DST_MAC = dst_q.mac;
    assign bus.BUSY       = busy_q;
    assign bus.DROP_COUNT = drop_cnt_q;
endmodule
